// File: rtl/pulse_meas_pkg.sv
// Shared types and default sizes for the pulse width meter.
package pulse_meas_pkg;

    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned DROP_W_DEF = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear, load-to-one and saturation at all ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max
);

    logic [W-1:0] r_count;

    assign count  = r_count;
    assign at_max = (r_count == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load1) begin
            r_count <= {{(W-1){1'b0}}, 1'b1};
        end else if (inc && !at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_width_meter.sv
// Measures high time between rise/fall pulses; results go to a one-entry
// valid/ready register, and results arriving while it is blocked are counted as drops.
module pulse_width_meter
    import pulse_meas_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned DROP_W = DROP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              rise_pulse,
    input  logic              fall_pulse,
    output logic [CNT_W-1:0]  width_out,
    output logic              width_sat,
    output logic              width_valid,
    input  logic              width_ready,
    output logic [DROP_W-1:0] drop_cnt
);

    state_t r_state;
    state_t w_state_nxt;

    logic             w_cnt_clr;
    logic             w_cnt_load1;
    logic             w_cnt_inc;
    logic             w_capture;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_at_max;

    logic             w_drop;
    logic             w_drop_at_max;

    logic [CNT_W-1:0] r_width_out;
    logic             r_width_sat;
    logic             r_width_valid;

    sat_counter #(.W(CNT_W)) u_width_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_cnt_clr),
        .load1  (w_cnt_load1),
        .inc    (w_cnt_inc),
        .count  (w_cnt),
        .at_max (w_cnt_at_max)
    );

    sat_counter #(.W(DROP_W)) u_drop_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clear),
        .load1  (1'b0),
        .inc    (w_drop && !w_drop_at_max),
        .count  (drop_cnt),
        .at_max (w_drop_at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_load1 = 1'b0;
        w_cnt_inc   = 1'b0;
        w_capture   = 1'b0;
        if (clear) begin
            w_state_nxt = IDLE;
            w_cnt_clr   = 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (rise_pulse) begin
                        w_cnt_load1 = 1'b1;
                        w_state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    // Simultaneous rise+fall closes this pulse and opens the next one.
                    if (fall_pulse) begin
                        w_capture = 1'b1;
                        if (rise_pulse) begin
                            w_cnt_load1 = 1'b1;
                        end else begin
                            w_cnt_clr   = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end else if (rise_pulse) begin
                        w_cnt_load1 = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_drop = w_capture && r_width_valid && !width_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width_out   <= '0;
            r_width_sat   <= 1'b0;
            r_width_valid <= 1'b0;
        end else if (clear) begin
            r_width_out   <= '0;
            r_width_sat   <= 1'b0;
            r_width_valid <= 1'b0;
        end else if (w_capture) begin
            if (!r_width_valid || width_ready) begin
                r_width_out   <= w_cnt;
                r_width_sat   <= w_cnt_at_max;
                r_width_valid <= 1'b1;
            end
        end else if (width_ready) begin
            r_width_valid <= 1'b0;
        end
    end

    assign width_out   = r_width_out;
    assign width_sat   = r_width_sat;
    assign width_valid = r_width_valid;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Scoreboard bench: a 16-bit and a 4-bit meter share stimulus; a monitor checks each handshake.
module tb_pulse_width_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        rise = 1'b0;
    logic        fall = 1'b0;
    logic        ready = 1'b0;

    logic [15:0] wo16;
    logic [3:0]  wo4;
    logic        sat16, sat4, v16, v4;
    logic [7:0]  d16, d4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int unsigned w;
        bit          s;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];
    exp_t e16, e4;

    always #5 clk = ~clk;

    pulse_width_meter dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .rise_pulse  (rise),
        .fall_pulse  (fall),
        .width_out   (wo16),
        .width_sat   (sat16),
        .width_valid (v16),
        .width_ready (ready),
        .drop_cnt    (d16)
    );

    pulse_width_meter #(.CNT_W(4), .DROP_W(8)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .rise_pulse  (rise),
        .fall_pulse  (fall),
        .width_out   (wo4),
        .width_sat   (sat4),
        .width_valid (v4),
        .width_ready (ready),
        .drop_cnt    (d4)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int unsigned w);
        exp_t e;
        e.w = w;
        e.s = 1'b0;
        q16.push_back(e);
        if (w >= 15) begin
            e.w = 15;
            e.s = 1'b1;
        end
        q4.push_back(e);
    endtask

    task automatic pulse(input int unsigned w, input bit expect_result);
        if (expect_result) push(w);
        rise = 1'b1;
        cyc();
        rise = 1'b0;
        repeat (w - 1) cyc();
        fall = 1'b1;
        cyc();
        fall = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (v16 && ready) begin
                if (q16.size() == 0) begin
                    chk("unexpected_result16", 1, 0);
                end else begin
                    e16 = q16.pop_front();
                    chk("width16", wo16, e16.w);
                    chk("sat16", sat16, e16.s);
                end
            end
            if (v4 && ready) begin
                if (q4.size() == 0) begin
                    chk("unexpected_result4", 1, 0);
                end else begin
                    e4 = q4.pop_front();
                    chk("width4", wo4, e4.w);
                    chk("sat4", sat4, e4.s);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cyc();
        chk("rst_width_out", wo16, 0);
        chk("rst_width_sat", sat16, 0);
        chk("rst_valid", v16, 0);
        chk("rst_drop", d16, 0);
        rst_n = 1'b1;
        cyc();

        // basic width 5, valid for one cycle with ready high
        ready = 1'b1;
        repeat (3) cyc();
        pulse(5, 1'b1);
        chk("w5_valid_next", v16, 1);
        cyc();
        chk("w5_valid_drop", v16, 0);

        // long pulse: 16-bit reports 20, 4-bit saturates
        pulse(20, 1'b1);
        cyc();
        cyc();

        // rise+fall together mid-measurement: capture 3, restart
        rise = 1'b1;
        cyc();
        rise = 1'b0;
        cyc();
        cyc();
        rise = 1'b1;
        fall = 1'b1;
        push(3);
        cyc();
        rise = 1'b0;
        fall = 1'b0;
        cyc();
        cyc();
        fall = 1'b1;
        push(3);
        cyc();
        fall = 1'b0;
        cyc();
        cyc();

        // back-to-back: held 2 accepted on the same cycle 6 is captured
        ready = 1'b0;
        pulse(2, 1'b1);
        cyc();
        chk("b2b_hold_valid", v16, 1);
        chk("b2b_hold_width", wo16, 2);
        rise = 1'b1;
        cyc();
        rise = 1'b0;
        repeat (5) cyc();
        fall = 1'b1;
        ready = 1'b1;
        push(6);
        cyc();
        fall = 1'b0;
        chk("b2b_valid_kept", v16, 1);
        chk("b2b_width6", wo16, 6);
        chk("b2b_drop0", d16, 0);
        cyc();
        chk("b2b_valid_drop", v16, 0);

        // blocked output: 3 held, 4 dropped
        ready = 1'b0;
        pulse(3, 1'b1);
        cyc();
        pulse(4, 1'b0);
        cyc();
        chk("blk_width_held", wo16, 3);
        chk("blk_valid", v16, 1);
        chk("blk_drop16", d16, 1);
        chk("blk_drop4", d4, 1);
        ready = 1'b1;
        cyc();
        chk("blk_valid_after", v16, 0);

        // reset mid-pulse discards the partial count
        rise = 1'b1;
        cyc();
        rise = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b0;
        cyc();
        chk("rstmid_valid", v16, 0);
        chk("rstmid_drop", d16, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        fall = 1'b1;
        cyc();
        fall = 1'b0;
        cyc();
        chk("rstmid_no_result", v16, 0);
        pulse(3, 1'b1);
        cyc();
        cyc();

        // clear with a held result and two drops
        ready = 1'b0;
        pulse(2, 1'b1);
        cyc();
        pulse(3, 1'b0);
        cyc();
        pulse(4, 1'b0);
        cyc();
        chk("clr_pre_drop", d16, 2);
        chk("clr_pre_valid", v16, 1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        q16.delete();
        q4.delete();
        chk("clr_valid", v16, 0);
        chk("clr_drop16", d16, 0);
        chk("clr_drop4", d4, 0);
        chk("clr_width", wo16, 0);
        fall = 1'b1;
        cyc();
        fall = 1'b0;
        cyc();
        chk("clr_lone_fall", v16, 0);

        // minimum width
        ready = 1'b1;
        pulse(1, 1'b1);
        cyc();
        cyc();

        chk("q16_drained", q16.size(), 0);
        chk("q4_drained", q4.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
